// File: rtl/vga_timing_compositor.sv
// VGA timing generator and 3-layer priority compositor, clocked from the system clock
// with an internal pixel-rate enable; RGB and sync are registered one pixel late.
module vga_timing_compositor #(
    parameter int          H_DISP   = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_DISP   = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter int          CLK_DIV  = 4,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  layer_on,
    input  logic [11:0] layer0_pixel,
    input  logic [11:0] layer1_pixel,
    input  logic [11:0] layer2_pixel,
    output logic        pix_tick,
    output logic [9:0]  h_cnt,
    output logic [9:0]  v_cnt,
    output logic        valid,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_red,
    output logic [3:0]  vga_green,
    output logic [3:0]  vga_blue,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISP);
    localparam logic [9:0] V_VIS    = 10'(V_DISP);
    localparam logic [9:0] HS_BEG   = 10'(H_DISP + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_DISP + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d, v_q, v_d;
    logic [15:0]      fcnt_q, fcnt_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             hs_q, vs_q;
    logic             hs_raw_n, vs_raw_n;
    logic             h_end, v_end;

    // Lowest set bit of layer_on wins; nothing on shows the background.
    function automatic logic [11:0] pick_layer(input logic [2:0]  on,
                                               input logic [11:0] p0,
                                               input logic [11:0] p1,
                                               input logic [11:0] p2);
        logic [11:0] res;
        res = BG_COLOR;
        if (on[0])      res = p0;
        else if (on[1]) res = p1;
        else if (on[2]) res = p2;
        return res;
    endfunction

    assign pix_tick    = (div_q == DIV_LAST);
    assign h_end       = (h_q == H_LAST);
    assign v_end       = (v_q == V_LAST);
    assign valid       = (h_q < H_VIS) && (v_q < V_VIS);
    assign frame_start = pix_tick && h_end && v_end;
    assign hs_raw_n    = !((h_q >= HS_BEG) && (h_q < HS_END));
    assign vs_raw_n    = !((v_q >= VS_BEG) && (v_q < VS_END));

    always_comb begin
        div_d  = pix_tick ? '0 : div_q + 1'b1;
        h_d    = h_q;
        v_d    = v_q;
        fcnt_d = fcnt_q;
        rgb_d  = valid ? pick_layer(layer_on, layer0_pixel, layer1_pixel, layer2_pixel)
                       : 12'h000;
        if (pix_tick) begin
            h_d = h_end ? 10'd0 : h_q + 10'd1;
            if (h_end) begin
                v_d = v_end ? 10'd0 : v_q + 10'd1;
                if (v_end) fcnt_d = fcnt_q + 16'd1;
            end
        end
    end

    // Sync and colour sample the pre-advance position, giving one pixel of latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            h_q    <= '0;
            v_q    <= '0;
            fcnt_q <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            rgb_q  <= '0;
        end else begin
            div_q  <= div_d;
            h_q    <= h_d;
            v_q    <= v_d;
            fcnt_q <= fcnt_d;
            if (pix_tick) begin
                hs_q  <= hs_raw_n;
                vs_q  <= vs_raw_n;
                rgb_q <= rgb_d;
            end
        end
    end

    assign h_cnt     = h_q;
    assign v_cnt     = v_q;
    assign frame_cnt = fcnt_q;
    assign hsync     = hs_q;
    assign vsync     = vs_q;
    assign vga_red   = rgb_q[11:8];
    assign vga_green = rgb_q[7:4];
    assign vga_blue  = rgb_q[3:0];

endmodule

// File: tb/tb_vga_timing_compositor.sv
// Bench for vga_timing_compositor using a shrunken raster so whole frames fit in a short run;
// expected values come from a clock-count model of the raster.
module tb_vga_timing_compositor;

    localparam int HD = 8, HF = 2, HS = 3, HB = 2;
    localparam int VD = 6, VF = 1, VS = 2, VB = 1;
    localparam int CD = 4;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam logic [11:0] BG = 12'h5A3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  layer_on = 3'b000;
    logic [11:0] l0 = 12'h000, l1 = 12'h000, l2 = 12'h000;
    logic        pix_tick, valid, hsync, vsync, frame_start;
    logic [9:0]  h_cnt, v_cnt;
    logic [3:0]  vga_red, vga_green, vga_blue;
    logic [15:0] frame_cnt;

    vga_timing_compositor #(
        .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(CD), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst(rst), .layer_on(layer_on),
        .layer0_pixel(l0), .layer1_pixel(l1), .layer2_pixel(l2),
        .pix_tick(pix_tick), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
        .hsync(hsync), .vsync(vsync),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int k     = 0;              // clock edges since reset release
    logic [11:0] exp_rgb = 12'h000;

    typedef struct {
        logic [2:0]  on;
        logic [11:0] p0, p1, p2;
        bit          blank;     // apply in horizontal blanking instead of visible area
        logic [11:0] exp;
    } vec_t;

    // Position of the raster after kk edges: one pixel per CD clocks.
    function automatic int pix_of(input int kk);
        return (kk / CD) % FR;
    endfunction
    function automatic int h_of(input int kk);
        return pix_of(kk) % HT;
    endfunction
    function automatic int v_of(input int kk);
        return pix_of(kk) / HT;
    endfunction
    function automatic bit vis_of(input int kk);
        return (h_of(kk) < HD) && (v_of(kk) < VD);
    endfunction

    function automatic logic [11:0] ref_rgb(input bit vis, input logic [2:0] on,
                                            input logic [11:0] a, input logic [11:0] b,
                                            input logic [11:0] c);
        logic [11:0] px [3];
        px[0] = a; px[1] = b; px[2] = c;
        if (!vis) return 12'h000;
        for (int i = 0; i < 3; i++)
            if (on[i]) return px[i];
        return BG;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h k=%0d t=%0t", name, act, exp, k, $time);
        end
    endtask

    task automatic check_all();
        int prev;
        int hs_exp, vs_exp;
        hs_exp = 1;
        vs_exp = 1;
        if (k >= CD) begin
            prev   = (k / CD - 1) % FR;
            hs_exp = ((prev % HT) >= HD + HF && (prev % HT) < HD + HF + HS) ? 0 : 1;
            vs_exp = ((prev / HT) >= VD + VF && (prev / HT) < VD + VF + VS) ? 0 : 1;
        end
        check("h_cnt", 32'(h_cnt), 32'(h_of(k)));
        check("v_cnt", 32'(v_cnt), 32'(v_of(k)));
        check("pix_tick", 32'(pix_tick), 32'((k % CD) == CD - 1));
        check("valid", 32'(valid), 32'(vis_of(k)));
        check("frame_start", 32'(frame_start),
              32'(((k % CD) == CD - 1) && (pix_of(k) == FR - 1)));
        check("frame_cnt", 32'(frame_cnt), 32'((k / CD / FR) % 65536));
        check("hsync", 32'(hsync), 32'(hs_exp));
        check("vsync", 32'(vsync), 32'(vs_exp));
        check("rgb", 32'({vga_red, vga_green, vga_blue}), 32'(exp_rgb));
    endtask

    // One clock: latch the expected colour if this edge carries a pixel tick.
    task automatic step();
        if ((k % CD) == CD - 1)
            exp_rgb = ref_rgb(vis_of(k), layer_on, l0, l1, l2);
        @(posedge clk);
        #1;
        k++;
        check_all();
    endtask

    vec_t vecs [7];
    int   guard;

    initial begin
        vecs[0] = '{3'b011, 12'hF00, 12'h0F0, 12'h000, 1'b0, 12'hF00};
        vecs[1] = '{3'b100, 12'h000, 12'h000, 12'h00F, 1'b0, 12'h00F};
        vecs[2] = '{3'b000, 12'h123, 12'h456, 12'h789, 1'b0, BG};
        vecs[3] = '{3'b110, 12'hABC, 12'hDEF, 12'h111, 1'b0, 12'hDEF};
        vecs[4] = '{3'b001, 12'h7F7, 12'h000, 12'h000, 1'b0, 12'h7F7};
        vecs[5] = '{3'b111, 12'hF00, 12'h0F0, 12'h00F, 1'b1, 12'h000};
        vecs[6] = '{3'b000, 12'hFFF, 12'hFFF, 12'hFFF, 1'b1, 12'h000};

        // Reset state
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        k = 0;
        exp_rgb = 12'h000;
        check_all();
        rst = 1'b0;

        // Two full frames of random layer traffic
        for (int n = 0; n < 2 * FR * CD; n++) begin
            layer_on = 3'($urandom_range(0, 7));
            l0 = 12'($urandom);
            l1 = 12'($urandom);
            l2 = 12'($urandom);
            step();
        end
        check("frame_cnt_after_2", 32'(frame_cnt), 32'd2);

        // Directed priority and blanking vectors
        for (int i = 0; i < 7; i++) begin
            layer_on = vecs[i].on;
            l0 = vecs[i].p0;
            l1 = vecs[i].p1;
            l2 = vecs[i].p2;
            guard = 0;
            while (!((k % CD) == CD - 1 &&
                     (vecs[i].blank ? (h_of(k) >= HD) : vis_of(k))) && guard < 2 * FR * CD) begin
                step();
                guard++;
            end
            check("vec_wait", 32'(guard < 2 * FR * CD), 32'd1);
            step();
            check("vec_rgb", 32'({vga_red, vga_green, vga_blue}), 32'(vecs[i].exp));
            for (int j = 0; j < CD - 1; j++) step();
            check("vec_rgb_hold", 32'({vga_red, vga_green, vga_blue}), 32'(vecs[i].exp));
        end

        // Mid-frame reset at a non-trivial position
        layer_on = 3'b111;
        l0 = 12'hFFF;
        guard = 0;
        while (!(v_of(k) == 3 && h_of(k) == 5) && guard < 2 * FR * CD) begin
            step();
            guard++;
        end
        check("rst_wait", 32'(guard < 2 * FR * CD), 32'd1);
        rst = 1'b1;
        #1;
        k = 0;
        exp_rgb = 12'h000;
        check_all();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        for (int n = 0; n < FR * CD + 20; n++) begin
            layer_on = 3'($urandom_range(0, 7));
            l0 = 12'($urandom);
            l1 = 12'($urandom);
            l2 = 12'($urandom);
            step();
        end
        check("frame_cnt_after_rst", 32'(frame_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
